// File: rtl/code_ctrl_pkg.sv
// Shared constants for the keypad code-check controller: state encoding and
// entry geometry (digit width, digits per code).
package code_ctrl_pkg;

  localparam int DIGIT_W   = 4;
  localparam int CODE_LEN  = 4;
  localparam int ENTRY_W   = DIGIT_W * CODE_LEN;
  localparam int MAX_DIGIT = 9;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ENTER  = 3'd1,
    S_CHECK  = 3'd2,
    S_UNLOCK = 3'd3,
    S_ALARM  = 3'd4
  } state_t;

  function automatic logic digit_ok(input logic [DIGIT_W-1:0] d);
    return d <= DIGIT_W'(MAX_DIGIT);
  endfunction

endpackage

// File: rtl/code_ctrl_hold.sv
// Hold timer shared by UNLOCK and ALARM: counts 0..len-1 after start and
// raises a one-cycle done pulse on the last cycle of the hold.
module hold_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] len,
  output logic        done
);

  logic [31:0] cnt_q, cnt_d;
  logic        run_q, run_d;

  always_comb begin
    cnt_d = cnt_q;
    run_d = run_q;
    done  = run_q && (cnt_q == len - 32'd1);
    if (start) begin
      cnt_d = '0;
      run_d = 1'b1;
    end else if (done) begin
      cnt_d = '0;
      run_d = 1'b0;
    end else if (run_q) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/code_ctrl.sv
// Keypad code-check controller: buffers up to four digits, compares on confirm,
// drives a timed unlock on success and a timed alarm after MAX_FAIL failures.
module code_ctrl
  import code_ctrl_pkg::*;
#(
  parameter logic [15:0] CODE      = 16'h1234,
  parameter int          MAX_FAIL  = 3,
  parameter int          ALARM_CYC = 625_000_000,
  parameter int          OK_CYC    = 250_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_vld,
  input  logic [DIGIT_W-1:0] key_digit,
  input  logic               key_confirm,
  input  logic               key_clear,
  output logic               alarm_en,
  output logic               unlock,
  output logic [2:0]         digit_cnt,
  output logic [1:0]         fail_cnt
);

  localparam logic [2:0] MAX_FAIL_C = 3'(MAX_FAIL);
  localparam logic [2:0] FULL_C     = 3'(CODE_LEN);

  state_t             state_q, state_d;
  logic [ENTRY_W-1:0] entry_q, entry_d;
  logic [2:0]         dcnt_q, dcnt_d;
  logic [1:0]         fail_q, fail_d;
  logic               unlock_q, unlock_d;
  logic               alarm_q, alarm_d;

  logic        hold_start;
  logic        hold_done;
  logic [31:0] hold_len;
  logic [2:0]  fail_inc;
  logic        match;

  assign fail_inc = {1'b0, fail_q} + 3'd1;
  assign match    = (dcnt_q == FULL_C) && (entry_q == CODE);
  assign hold_len = (state_q == S_ALARM) ? 32'(ALARM_CYC) : 32'(OK_CYC);

  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    dcnt_d  = dcnt_q;
    fail_d  = fail_q;
    case (state_q)
      S_IDLE, S_ENTER: begin
        // clear outranks confirm, which outranks a digit in the same cycle
        if (key_clear) begin
          entry_d = '0;
          dcnt_d  = '0;
          state_d = S_IDLE;
        end else if (key_confirm) begin
          state_d = S_CHECK;
        end else if (key_vld && digit_ok(key_digit) && (dcnt_q != FULL_C)) begin
          entry_d = {entry_q[ENTRY_W-DIGIT_W-1:0], key_digit};
          dcnt_d  = dcnt_q + 3'd1;
          state_d = S_ENTER;
        end
      end
      S_CHECK: begin
        entry_d = '0;
        dcnt_d  = '0;
        if (match) begin
          fail_d  = '0;
          state_d = S_UNLOCK;
        end else if (fail_inc < MAX_FAIL_C) begin
          fail_d  = fail_inc[1:0];
          state_d = S_IDLE;
        end else begin
          fail_d  = MAX_FAIL_C[1:0];
          state_d = S_ALARM;
        end
      end
      S_UNLOCK: begin
        if (hold_done) state_d = S_IDLE;
      end
      S_ALARM: begin
        if (hold_done) begin
          fail_d  = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        entry_d = '0;
        dcnt_d  = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs follow the next state so they are registered yet aligned with it.
  always_comb begin
    unlock_d   = (state_d == S_UNLOCK);
    alarm_d    = (state_d == S_ALARM);
    hold_start = (state_d != state_q) && (unlock_d || alarm_d);
  end

  hold_timer u_hold (
    .clk   (clk),
    .rst   (rst),
    .start (hold_start),
    .len   (hold_len),
    .done  (hold_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      entry_q  <= '0;
      dcnt_q   <= '0;
      fail_q   <= '0;
      unlock_q <= 1'b0;
      alarm_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      entry_q  <= entry_d;
      dcnt_q   <= dcnt_d;
      fail_q   <= fail_d;
      unlock_q <= unlock_d;
      alarm_q  <= alarm_d;
    end
  end

  assign alarm_en  = alarm_q;
  assign unlock    = unlock_q;
  assign digit_cnt = dcnt_q;
  assign fail_cnt  = fail_q;

endmodule
